// File: rtl/cu_pkg.sv
// Shared CU types: array selectors, vertex sequencer states, job bundle.
// Also provides the power-of-two read command size helper.
package cu_pkg;

    typedef enum logic [2:0] {
        STRUCT_NONE    = 3'd0,
        INV_OUT_DEGREE = 3'd1,
        INV_EDGES_IDX  = 3'd2
    } array_struct_type;

    typedef enum logic [2:0] {
        SEND_VERTEX_IDLE           = 3'd0,
        CALC_VERTEX_REQ_SIZE       = 3'd1,
        SEND_VERTEX_INV_OUT_DEGREE = 3'd2,
        SEND_VERTEX_INV_EDGES_IDX  = 3'd3,
        WAIT_VERTEX_DATA           = 3'd4,
        SEND_VERTEX_DONE           = 3'd5
    } vertex_struct_state;

    typedef struct packed {
        logic [31:0] vertex_id;
        logic [31:0] remaining;
        logic [63:0] inv_out_degree_addr;
        logic [63:0] inv_edges_idx_addr;
    } vertex_job_t;

    // Smallest power of two >= bytes, capped at 2048.
    function automatic logic [11:0] cmd_size_pow2(input logic [31:0] bytes);
        logic [11:0] s;
        s = 12'd1;
        for (int i = 0; i < 11; i++) begin
            if (32'(s) < bytes) begin
                s = s << 1;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/cu_read_credit_counter.sv
// Outstanding read credit counter: take on issue, give on response.
// Saturates at CREDITS so a stray response cannot overflow it.
module cu_read_credit_counter
    import cu_pkg::*;
#(
    parameter  int CREDITS = 16,
    localparam int W       = $clog2(CREDITS + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         take,
    input  logic         give,
    output logic [W-1:0] avail,
    output logic         all_returned
);

    localparam logic [W-1:0] FULL = W'(CREDITS);

    assign all_returned = (avail == FULL);

    // Credit bookkeeping; simultaneous take and give cancel out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            avail <= FULL;
        end else begin
            unique case ({take, give})
                2'b10: if (avail != '0) avail <= avail - 1'b1;
                2'b01: if (avail != FULL) avail <= avail + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cu_vertex_request_sequencer.sv
// Splits a vertex range into paired inverse-out-degree / inverse-edges-index
// read commands, gated by read credits. Optional: CU_VERTEX_REQ_PERF_EN.
module cu_vertex_request_sequencer
    import cu_pkg::*;
#(
    parameter int VERTEX_SIZE   = 4,
    parameter int MAX_CMD_BYTES = 128,
    parameter int CREDITS       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_in,
    input  logic [31:0]      vertex_base_in,
    input  logic [31:0]      vertex_count_in,
    input  logic [63:0]      inv_out_degree_addr_in,
    input  logic [63:0]      inv_edges_idx_addr_in,
    output logic             cmd_valid_out,
    input  logic             cmd_ready_in,
    output array_struct_type cmd_array_out,
    output logic [63:0]      cmd_addr_out,
    output logic [11:0]      cmd_size_out,
    output logic [31:0]      cmd_vertex_id_out,
    input  logic             rsp_done_in,
    output logic             busy_out,
`ifdef CU_VERTEX_REQ_PERF_EN
    output logic [31:0]      perf_cmd_count_out,
    output logic [31:0]      perf_stall_cycles_out,
`endif
    output logic             done_out
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [31:0] MAX_CHUNK = 32'(MAX_CMD_BYTES / VERTEX_SIZE);
    localparam logic [31:0] VSZ32 = 32'(VERTEX_SIZE);
    localparam logic [63:0] VSZ64 = 64'(VERTEX_SIZE);

    vertex_struct_state state;
    vertex_struct_state next_state;

    vertex_job_t job;
    logic [31:0] chunk;
    logic [11:0] size_q;

    logic [CW-1:0] credits_avail;
    logic          credits_full;
    logic          has_credit;
    logic          xfer;
    logic [31:0]   chunk_calc;
    logic [63:0]   vid_off;

    assign has_credit = (credits_avail != '0);
    assign xfer       = cmd_valid_out & cmd_ready_in;
    assign chunk_calc = (job.remaining < MAX_CHUNK) ? job.remaining : MAX_CHUNK;
    assign vid_off    = {32'd0, job.vertex_id} * VSZ64;

    cu_read_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credits (
        .clock        (clock),
        .reset        (reset),
        .take         (xfer),
        .give         (rsp_done_in),
        .avail        (credits_avail),
        .all_returned (credits_full)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SEND_VERTEX_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and command outputs; payload held constant in SEND states.
    always_comb begin
        next_state        = state;
        cmd_valid_out     = 1'b0;
        cmd_array_out     = STRUCT_NONE;
        cmd_addr_out      = 64'd0;
        cmd_size_out      = 12'd0;
        cmd_vertex_id_out = 32'd0;
        busy_out          = 1'b0;
        done_out          = 1'b0;
        unique case (state)
            SEND_VERTEX_IDLE: begin
                if (start_in) next_state = CALC_VERTEX_REQ_SIZE;
            end
            CALC_VERTEX_REQ_SIZE: begin
                busy_out = 1'b1;
                if (job.remaining == 32'd0) begin
                    next_state = WAIT_VERTEX_DATA;
                end else begin
                    next_state = SEND_VERTEX_INV_OUT_DEGREE;
                end
            end
            SEND_VERTEX_INV_OUT_DEGREE: begin
                busy_out          = 1'b1;
                cmd_valid_out     = has_credit;
                cmd_array_out     = INV_OUT_DEGREE;
                cmd_addr_out      = job.inv_out_degree_addr + vid_off;
                cmd_size_out      = size_q;
                cmd_vertex_id_out = job.vertex_id;
                if (has_credit && cmd_ready_in) begin
                    next_state = SEND_VERTEX_INV_EDGES_IDX;
                end
            end
            SEND_VERTEX_INV_EDGES_IDX: begin
                busy_out          = 1'b1;
                cmd_valid_out     = has_credit;
                cmd_array_out     = INV_EDGES_IDX;
                cmd_addr_out      = job.inv_edges_idx_addr + vid_off;
                cmd_size_out      = size_q;
                cmd_vertex_id_out = job.vertex_id;
                if (has_credit && cmd_ready_in) begin
                    next_state = CALC_VERTEX_REQ_SIZE;
                end
            end
            WAIT_VERTEX_DATA: begin
                busy_out = 1'b1;
                if (credits_full) next_state = SEND_VERTEX_DONE;
            end
            SEND_VERTEX_DONE: begin
                done_out   = 1'b1;
                next_state = SEND_VERTEX_IDLE;
            end
            default: begin
                next_state = SEND_VERTEX_IDLE;
            end
        endcase
    end

    // Job latch, chunk sizing and progress through the vertex range.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            job    <= '0;
            chunk  <= 32'd0;
            size_q <= 12'd0;
        end else begin
            if (state == SEND_VERTEX_IDLE && start_in) begin
                job.vertex_id           <= vertex_base_in;
                job.remaining           <= vertex_count_in;
                job.inv_out_degree_addr <= inv_out_degree_addr_in;
                job.inv_edges_idx_addr  <= inv_edges_idx_addr_in;
            end
            if (state == CALC_VERTEX_REQ_SIZE && job.remaining != 32'd0) begin
                chunk  <= chunk_calc;
                size_q <= cmd_size_pow2(chunk_calc * VSZ32);
            end
            if (state == SEND_VERTEX_INV_EDGES_IDX && xfer) begin
                job.vertex_id <= job.vertex_id + chunk;
                job.remaining <= job.remaining - chunk;
            end
        end
    end

`ifdef CU_VERTEX_REQ_PERF_EN
    logic in_send;
    assign in_send = (state == SEND_VERTEX_INV_OUT_DEGREE) ||
                     (state == SEND_VERTEX_INV_EDGES_IDX);

    // Saturating command and stall counters, cleared by an accepted start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_cmd_count_out    <= 32'd0;
            perf_stall_cycles_out <= 32'd0;
        end else if (state == SEND_VERTEX_IDLE && start_in) begin
            perf_cmd_count_out    <= 32'd0;
            perf_stall_cycles_out <= 32'd0;
        end else begin
            if (xfer && perf_cmd_count_out != '1) begin
                perf_cmd_count_out <= perf_cmd_count_out + 32'd1;
            end
            if (in_send && !xfer && perf_stall_cycles_out != '1) begin
                perf_stall_cycles_out <= perf_stall_cycles_out + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cu_vertex_request_sequencer.sv
// Directed bench for cu_vertex_request_sequencer.
// A second instance with CREDITS=2 exercises credit starvation.
module tb_cu_vertex_request_sequencer;
    import cu_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic [31:0] vbase = 32'd0;
    logic [31:0] vcount = 32'd0;
    logic [63:0] od_addr = 64'h1000;
    logic [63:0] ei_addr = 64'h2000;
    logic ready = 1'b1;
    logic rsp = 1'b0;
    logic pend = 1'b0;
    logic rsp2 = 1'b0;
    logic auto_rsp = 1'b1;
    logic manual_rsp = 1'b0;

    logic valid, busy, done;
    array_struct_type arr;
    logic [63:0] addr;
    logic [11:0] size;
    logic [31:0] vid;
    logic valid2, busy2, done2;
    array_struct_type arr2;
    logic [63:0] addr2;
    logic [11:0] size2;
    logic [31:0] vid2;
`ifdef CU_VERTEX_REQ_PERF_EN
    logic [31:0] pc1, ps1, pc2, ps2;
`endif

    int errors = 0;
    int checks = 0;

    logic [2:0]  log_arr [64];
    logic [63:0] log_addr[64];
    logic [11:0] log_size[64];
    logic [31:0] log_vid [64];
    int          log_cyc [64];
    int n_cmds = 0;
    int n_cmds2 = 0;
    int n_done = 0;
    int cyc = 0;

    always #5 clock = ~clock;

    cu_vertex_request_sequencer dut (
        .clock                  (clock),
        .reset                  (reset),
        .start_in               (start),
        .vertex_base_in         (vbase),
        .vertex_count_in        (vcount),
        .inv_out_degree_addr_in (od_addr),
        .inv_edges_idx_addr_in  (ei_addr),
        .cmd_valid_out          (valid),
        .cmd_ready_in           (ready),
        .cmd_array_out          (arr),
        .cmd_addr_out           (addr),
        .cmd_size_out           (size),
        .cmd_vertex_id_out      (vid),
        .rsp_done_in            (rsp),
        .busy_out               (busy),
`ifdef CU_VERTEX_REQ_PERF_EN
        .perf_cmd_count_out     (pc1),
        .perf_stall_cycles_out  (ps1),
`endif
        .done_out               (done)
    );

    cu_vertex_request_sequencer #(.CREDITS(2)) dut2 (
        .clock                  (clock),
        .reset                  (reset),
        .start_in               (start2),
        .vertex_base_in         (vbase),
        .vertex_count_in        (vcount),
        .inv_out_degree_addr_in (od_addr),
        .inv_edges_idx_addr_in  (ei_addr),
        .cmd_valid_out          (valid2),
        .cmd_ready_in           (ready),
        .cmd_array_out          (arr2),
        .cmd_addr_out           (addr2),
        .cmd_size_out           (size2),
        .cmd_vertex_id_out      (vid2),
        .rsp_done_in            (rsp2),
        .busy_out               (busy2),
`ifdef CU_VERTEX_REQ_PERF_EN
        .perf_cmd_count_out     (pc2),
        .perf_stall_cycles_out  (ps2),
`endif
        .done_out               (done2)
    );

    // Mid-cycle monitor: logs transfers, counts done pulses, returns responses.
    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (valid && ready) begin
            if (n_cmds < 64) begin
                log_arr[n_cmds]  <= arr;
                log_addr[n_cmds] <= addr;
                log_size[n_cmds] <= size;
                log_vid[n_cmds]  <= vid;
                log_cyc[n_cmds]  <= cyc;
            end
            n_cmds <= n_cmds + 1;
        end
        if (valid2 && ready) n_cmds2 <= n_cmds2 + 1;
        if (done) n_done <= n_done + 1;
        if (auto_rsp) begin
            rsp  <= pend;
            pend <= valid && ready;
        end else begin
            rsp  <= manual_rsp;
            pend <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input int d0, input string tag);
        for (int k = 0; k < 500 && n_done == d0; k++) tick();
        check(tag, 64'(n_done - d0), 64'd1);
    endtask

    task automatic run_job(input logic [31:0] b, input logic [31:0] c,
                           input string tag);
        int d0;
        d0 = n_done;
        vbase = b;
        vcount = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(d0, tag);
    endtask

    task automatic check_cmd(input int idx, input string tag,
                             input logic [2:0] ea, input logic [63:0] ead,
                             input logic [11:0] es, input logic [31:0] ev);
        check({tag, "_arr"},  64'(log_arr[idx]),  64'(ea));
        check({tag, "_addr"}, log_addr[idx],      ead);
        check({tag, "_size"}, 64'(log_size[idx]), 64'(es));
        check({tag, "_vid"},  64'(log_vid[idx]),  64'(ev));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cb;
        int d0;
        int c2;
        logic hold;
        logic [63:0] h_addr;
        logic [46:0] h_rest;
        logic [31:0] ev[3];
        logic [11:0] es[3];

        repeat (3) tick();
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_done",  64'(done),  64'd0);
        check("rst_payload", {arr, size, vid} , 64'd0);
        check("rst_addr",  addr, 64'd0);
        reset = 1'b0;
        tick();

        // count=10: one pair of 64-byte commands.
        cb = n_cmds;
        d0 = n_done;
        vbase = 32'd0;
        vcount = 32'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_lat1_valid", 64'(valid), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        tick();
        check("t1_lat2_valid", 64'(valid), 64'd1);
        wait_done(d0, "t1_done");
        check("t1_ncmds", 64'(n_cmds - cb), 64'd2);
        check_cmd(cb, "t1_c0", INV_OUT_DEGREE, 64'h1000, 12'd64, 32'd0);
        check_cmd(cb + 1, "t1_c1", INV_EDGES_IDX, 64'h2000, 12'd64, 32'd0);
        tick();
        check("t1_idle_busy", 64'(busy), 64'd0);

        // count=70 base=5: chunks 32/32/6.
        cb = n_cmds;
        run_job(32'd5, 32'd70, "t2_done");
        check("t2_ncmds", 64'(n_cmds - cb), 64'd6);
        ev = '{32'd5, 32'd37, 32'd69};
        es = '{12'd128, 12'd128, 12'd32};
        for (int i = 0; i < 3; i++) begin
            check_cmd(cb + 2 * i, $sformatf("t2_od%0d", i), INV_OUT_DEGREE,
                      64'h1000 + 64'(ev[i]) * 4, es[i], ev[i]);
            check_cmd(cb + 2 * i + 1, $sformatf("t2_ei%0d", i), INV_EDGES_IDX,
                      64'h2000 + 64'(ev[i]) * 4, es[i], ev[i]);
        end
        check("t2_pair_period", 64'(log_cyc[cb + 2] - log_cyc[cb]), 64'd3);

        // count=0: done exactly 3 cycles after start.
        cb = n_cmds;
        vcount = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_done_c1", 64'(done), 64'd0);
        tick();
        check("t3_done_c2", 64'(done), 64'd0);
        tick();
        check("t3_done_c3", 64'(done), 64'd1);
        tick();
        check("t3_done_c4", 64'(done), 64'd0);
        check("t3_ncmds", 64'(n_cmds - cb), 64'd0);

        // Random ready: payload holds while stalled, no loss/duplication.
        cb = n_cmds;
        d0 = n_done;
        vbase = 32'd100;
        vcount = 32'd40;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 300 && n_done == d0; k++) begin
            ready = 1'($urandom_range(0, 1));
            hold = valid && !ready;
            h_addr = addr;
            h_rest = {arr, size, vid};
            tick();
            if (hold) begin
                check("t4_hold_valid", 64'(valid), 64'd1);
                check("t4_hold_addr", addr, h_addr);
                check("t4_hold_rest", 64'({arr, size, vid}), 64'(h_rest));
            end
        end
        ready = 1'b1;
        check("t4_done", 64'(n_done - d0), 64'd1);
        check("t4_ncmds", 64'(n_cmds - cb), 64'd4);
        check_cmd(cb,     "t4_c0", INV_OUT_DEGREE, 64'h1190, 12'd128, 32'd100);
        check_cmd(cb + 1, "t4_c1", INV_EDGES_IDX,  64'h2190, 12'd128, 32'd100);
        check_cmd(cb + 2, "t4_c2", INV_OUT_DEGREE, 64'h1210, 12'd32,  32'd132);
        check_cmd(cb + 3, "t4_c3", INV_EDGES_IDX,  64'h2210, 12'd32,  32'd132);

        // CREDITS=2 with responses withheld.
        c2 = n_cmds2;
        vbase = 32'd0;
        vcount = 32'd100;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (10) tick();
        check("t5_issued", 64'(n_cmds2 - c2), 64'd2);
        check("t5_starved_valid", 64'(valid2), 64'd0);
        check("t5_busy", 64'(busy2), 64'd1);
        rsp2 = 1'b1;
        tick();
        rsp2 = 1'b0;
        check("t5_resume_valid", 64'(valid2), 64'd1);
        tick();
        check("t5_issued3", 64'(n_cmds2 - c2), 64'd3);
        check("t5_starved2", 64'(valid2), 64'd0);

        // Reset mid-job aborts it; then saturate credits and rerun.
        d0 = n_done;
        vcount = 32'd200;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 64'(valid), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_addr", addr, 64'd0);
        tick();
        check("t6_rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        repeat (20) tick();
        check("t6_no_old_done", 64'(n_done - d0), 64'd0);
        auto_rsp = 1'b0;
        manual_rsp = 1'b1;
        repeat (3) tick();
        manual_rsp = 1'b0;
        tick();
        auto_rsp = 1'b1;
        cb = n_cmds;
        run_job(32'd0, 32'd10, "t6_new_done");
        check("t6_ncmds", 64'(n_cmds - cb), 64'd2);
        check_cmd(cb + 1, "t6_c1", INV_EDGES_IDX, 64'h2000, 12'd64, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
